// File: rtl/sc_io_unit_pkg.sv
// Shared constants and write payload for the memory-stage IO unit.
package sc_io_unit_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IO_SEL_BIT = 7;
  localparam int unsigned TCTRL_W    = 3;

  // Byte offsets of the IO registers (addr[7] set selects the IO bank)
  localparam logic [7:0] IO_SW      = 8'h80;
  localparam logic [7:0] IO_KEYEDGE = 8'h84;
  localparam logic [7:0] IO_LED     = 8'h88;
  localparam logic [7:0] IO_HEX     = 8'h8C;
  localparam logic [7:0] IO_TCNT    = 8'h90;
  localparam logic [7:0] IO_TCMP    = 8'h94;
  localparam logic [7:0] IO_TCTRL   = 8'h98;

  localparam int unsigned TC_EN = 0;
  localparam int unsigned TC_AR = 1;
  localparam int unsigned TC_MF = 2;

  typedef struct packed {
    logic              tcmp_we;
    logic              tctrl_we;
    logic [DATA_W-1:0] wdata;
  } tmr_wr_t;

endpackage

// File: rtl/sc_io_unit_io_timer.sv
// Compare timer: free-running count, match flag with optional autoreload.
module io_timer
  import sc_io_unit_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  tmr_wr_t            wr,
  output logic [DATA_W-1:0]  tcnt,
  output logic [DATA_W-1:0]  tcmp,
  output logic [TCTRL_W-1:0] tctrl,
  output logic               irq
);

  logic match;
  logic flag_clr;

  assign match    = tctrl[TC_EN] && (tcnt == tcmp);
  assign flag_clr = wr.tctrl_we && wr.wdata[TC_MF];
  assign irq      = tctrl[TC_MF];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt  <= '0;
      tcmp  <= '0;
      tctrl <= '0;
    end else begin
      if (tctrl[TC_EN]) begin
        tcnt <= (match && tctrl[TC_AR]) ? '0 : tcnt + DATA_W'(1);
      end
      if (wr.tcmp_we) begin
        tcmp <= wr.wdata;
      end
      if (wr.tctrl_we) begin
        tctrl[TC_EN] <= wr.wdata[TC_EN];
        tctrl[TC_AR] <= wr.wdata[TC_AR];
      end
      // A new match outranks a same-cycle clear
      tctrl[TC_MF] <= match || (tctrl[TC_MF] && !flag_clr);
    end
  end

endmodule

// File: rtl/sc_io_unit.sv
// Memory-stage IO unit: splits data accesses between external RAM and IO registers.
module sc_io_unit
  import sc_io_unit_pkg::*;
#(
  parameter int unsigned SW_W  = 10,
  parameter int unsigned KEY_W = 4,
  parameter int unsigned LED_W = 10,
  parameter int unsigned HEX_W = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wmem,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [DATA_W-1:0] rdata,
  input  logic [SW_W-1:0]   sw,
  input  logic [KEY_W-1:0]  key,
  output logic [LED_W-1:0]  led,
  output logic [HEX_W-1:0]  hex,
  output logic              timer_irq
);

  logic               io_sel;
  logic               io_wr;
  logic [7:0]         off;
  logic               unused_addr_bits;

  logic [SW_W-1:0]    sw_s1, sw_s2;
  logic [KEY_W-1:0]   key_s1, key_s2, key_s3;
  logic [KEY_W-1:0]   key_fall;
  logic [KEY_W-1:0]   ke_clr;
  logic [KEY_W-1:0]   keyedge;

  tmr_wr_t            tmr_wr;
  logic [DATA_W-1:0]  tcnt, tcmp;
  logic [TCTRL_W-1:0] tctrl;
  logic [DATA_W-1:0]  io_rdata;

  assign io_sel           = addr[IO_SEL_BIT];
  assign off              = {addr[7:2], 2'b00};
  assign io_wr            = wmem && io_sel;
  assign ram_we           = wmem && !io_sel;
  assign unused_addr_bits = ^{addr[DATA_W-1:8], addr[1:0]};

  // Two-flop synchronizers; key stage 3 holds the previous synced value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '1;
      key_s2 <= '1;
      key_s3 <= '1;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      key_s1 <= key;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  assign key_fall = key_s3 & ~key_s2;
  assign ke_clr   = (io_wr && off == IO_KEYEDGE) ? wdata[KEY_W-1:0] : '0;

  // Sticky edge capture, set outranks write-1-to-clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keyedge <= '0;
      led     <= '0;
      hex     <= '0;
    end else begin
      keyedge <= (keyedge & ~ke_clr) | key_fall;
      if (io_wr && off == IO_LED) begin
        led <= wdata[LED_W-1:0];
      end
      if (io_wr && off == IO_HEX) begin
        hex <= wdata[HEX_W-1:0];
      end
    end
  end

  always_comb begin
    tmr_wr          = '0;
    tmr_wr.tcmp_we  = io_wr && (off == IO_TCMP);
    tmr_wr.tctrl_we = io_wr && (off == IO_TCTRL);
    tmr_wr.wdata    = wdata;
  end

  io_timer u_timer (
    .clock (clock),
    .reset (reset),
    .wr    (tmr_wr),
    .tcnt  (tcnt),
    .tcmp  (tcmp),
    .tctrl (tctrl),
    .irq   (timer_irq)
  );

  always_comb begin
    io_rdata = '0;
    case (off)
      IO_SW:      io_rdata = DATA_W'(sw_s2);
      IO_KEYEDGE: io_rdata = DATA_W'(keyedge);
      IO_LED:     io_rdata = DATA_W'(led);
      IO_HEX:     io_rdata = DATA_W'(hex);
      IO_TCNT:    io_rdata = tcnt;
      IO_TCMP:    io_rdata = tcmp;
      IO_TCTRL:   io_rdata = DATA_W'(tctrl);
      default:    io_rdata = '0;
    endcase
  end

  assign rdata = io_sel ? io_rdata : ram_rdata;

endmodule

// File: tb/tb_sc_io_unit.sv
// Directed plus randomized bench for sc_io_unit against a behavioural register-map model.
module tb_sc_io_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wmem = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        ram_we;
  logic [31:0] rdata;
  logic [9:0]  sw = '0;
  logic [3:0]  key = 4'hF;
  logic [9:0]  led;
  logic [23:0] hex;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  // Model state: register contents plus input sample history (index 0 = latest edge)
  logic [9:0]  m_led;
  logic [23:0] m_hex;
  logic [31:0] m_tcnt, m_tcmp;
  logic        m_en, m_ar, m_mf;
  logic [3:0]  m_ke;
  logic [3:0]  key_h [3];
  logic [9:0]  sw_h [2];

  sc_io_unit dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .wmem      (wmem),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .rdata     (rdata),
    .sw        (sw),
    .key       (key),
    .led       (led),
    .hex       (hex),
    .timer_irq (timer_irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_hex = '0; m_tcnt = '0; m_tcmp = '0;
    m_en = 0; m_ar = 0; m_mf = 0; m_ke = '0;
    for (int i = 0; i < 3; i++) key_h[i] = 4'hF;
    for (int i = 0; i < 2; i++) sw_h[i] = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!a[7]) return ram_rdata;
    case ({a[7:2], 2'b00})
      8'h80:   return {22'd0, sw_h[1]};
      8'h84:   return {28'd0, m_ke};
      8'h88:   return {22'd0, m_led};
      8'h8C:   return {8'd0, m_hex};
      8'h90:   return m_tcnt;
      8'h94:   return m_tcmp;
      8'h98:   return {29'd0, m_mf, m_ar, m_en};
      default: return 32'd0;
    endcase
  endfunction

  // Apply the register-map rules for one rising edge using the pre-edge inputs
  task automatic model_edge();
    logic       io_w, match;
    logic [7:0] o;
    logic [3:0] fall, clr;
    if (reset) begin
      model_reset();
      return;
    end
    io_w  = wmem && addr[7];
    o     = {addr[7:2], 2'b00};
    match = m_en && (m_tcnt == m_tcmp);
    fall  = key_h[2] & ~key_h[1];
    clr   = (io_w && o == 8'h84) ? wdata[3:0] : 4'h0;
    m_ke  = (m_ke & ~clr) | fall;
    if (m_en) m_tcnt = (match && m_ar) ? 32'd0 : m_tcnt + 32'd1;
    m_mf = match || (m_mf && !(io_w && o == 8'h98 && wdata[2]));
    if (io_w && o == 8'h98) begin m_en = wdata[0]; m_ar = wdata[1]; end
    if (io_w && o == 8'h94) m_tcmp = wdata;
    if (io_w && o == 8'h88) m_led = wdata[9:0];
    if (io_w && o == 8'h8C) m_hex = wdata[23:0];
    key_h[2] = key_h[1]; key_h[1] = key_h[0]; key_h[0] = key;
    sw_h[1] = sw_h[0]; sw_h[0] = sw;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wmem = 1'b1;
    tick();
    wmem = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; wmem = 1'b0;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_led"}, 32'(led), 32'(m_led));
    chk({tag, "_hex"}, 32'(hex), 32'(m_hex));
    chk({tag, "_irq"}, 32'(timer_irq), 32'(m_mf));
  endtask

  initial begin
    logic        found;
    logic [31:0] a;
    model_reset();
    tick(); tick();
    #2 reset = 1'b0;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_hex", 32'(hex), 32'd0);
    chk("rst_irq", 32'(timer_irq), 32'd0);

    // RAM pass-through and IO write blocking of ram_we
    addr = 32'h10; wdata = 32'h55; wmem = 1'b1; ram_rdata = 32'hDEADBEEF;
    #1;
    chk("ram_we_ram", 32'(ram_we), 32'd1);
    chk("ram_rdata", rdata, 32'hDEADBEEF);
    tick();
    addr = 32'h88; wdata = 32'hFFFFFFFF;
    #1;
    chk("ram_we_io", 32'(ram_we), 32'd0);
    tick();
    wmem = 1'b0;
    chk("led_out", 32'(led), 32'h3FF);
    rd("led_rd", 32'h88, 32'h0000_03FF);

    wr(32'h8C, 32'hAB12_3456);
    chk("hex_out", 32'(hex), 32'h0012_3456);
    rd("hex_rd", 32'h8C, 32'h0012_3456);
    wr(32'hBC, 32'hFFFF_FFFF);
    rd("unmapped_rd", 32'hBC, 32'd0);
    rd("hex_rd_after_unmapped", 32'h8F, 32'h0012_3456);

    // Switch synchronizer latency
    sw = 10'h2A5;
    tick();
    rd("sw_edge1", 32'h80, 32'd0);
    tick();
    rd("sw_edge2", 32'h80, 32'h2A5);

    // Key press capture, stickiness, clear, and set-beats-clear
    key = 4'b1011;
    for (int i = 1; i <= 4; i++) begin
      tick();
      rd($sformatf("key_press_clk%0d", i), 32'h84, (i >= 3) ? 32'h4 : 32'h0);
    end
    key = 4'hF;
    tick(); tick(); tick();
    rd("key_sticky", 32'h84, 32'h4);
    wr(32'h84, 32'h4);
    rd("key_clear", 32'h84, 32'h0);
    key = 4'b1011;
    tick(); tick();
    wr(32'h84, 32'h4);
    rd("key_set_wins", 32'h84, 32'h4);
    key = 4'hF;

    // Timer with autoreload
    wr(32'h94, 32'd5);
    wr(32'h98, 32'h3);
    for (int i = 1; i <= 6; i++) begin
      tick();
      rd($sformatf("tcnt_ar_%0d", i), 32'h90, (i == 6) ? 32'd0 : 32'(i));
      chk($sformatf("irq_ar_%0d", i), 32'(timer_irq), (i == 6) ? 32'd1 : 32'd0);
    end
    wr(32'h98, 32'h7);
    chk("irq_clear", 32'(timer_irq), 32'd0);
    wr(32'h98, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      addr = 32'h90;
      #1;
      if (rdata == 32'd6) found = 1'b1;
      else tick();
    end
    chk("tcnt_reach6", 32'(found), 32'd1);
    chk("irq_noreload", 32'(timer_irq), 32'd1);
    rd("tctrl_rd", 32'h98, 32'h5);

    // Asynchronous reset in the middle of counting
    tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_led", 32'(led), 32'd0);
    chk("rst_mid_hex", 32'(hex), 32'd0);
    chk("rst_mid_irq", 32'(timer_irq), 32'd0);
    rd("rst_mid_tcnt", 32'h90, 32'd0);
    tick();
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      rd($sformatf("rst_no_key_edge_%0d", i), 32'h84, 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      sw = 10'($urandom);
      if ($urandom_range(0, 7) == 0) key[$urandom_range(0, 3)] ^= 1'b1;
      a = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        a[7] = 1'b0;
      end else begin
        a[7] = 1'b1;
        if ($urandom_range(0, 4) != 0) a[6:2] = 5'($urandom_range(0, 6));
      end
      addr = a;
      wdata = $urandom;
      if ({a[7:2], 2'b00} == 8'h94) wdata = $urandom_range(0, 40);
      wmem = 1'($urandom_range(0, 1));
      ram_rdata = $urandom;
      #1;
      chk("rand_rdata", rdata, m_read(addr));
      chk("rand_ram_we", 32'(ram_we), 32'(wmem && !addr[7]));
      if (i == 300) begin
        reset = 1'b1;
        #1;
        model_reset();
        tick();
        #2 reset = 1'b0;
      end else begin
        tick();
      end
      check_outs("rand");
    end
    wmem = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
